// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_resp
//  Description : Word-organised data SRAM (2^ADDR_W x 32 bit) with byte-write
//                strobes and a one-entry posted-write buffer. Reads return the
//                array word merged with any matching buffered bytes one cycle
//                after the request. Writes are parked in the buffer and drained
//                into the array on a later edge.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   clock, all state updates on rising edge
//    reset          in   1   asynchronous, active-high reset
//    data_sram_en   in   1   access request this cycle
//    data_sram_wen  in   4   byte-write strobes, all-zero = read
//    data_sram_addr in  32   byte address, word index = addr[ADDR_W+1:2]
//    data_sram_wdata in 32   lane-aligned store data
//    data_sram_rdata out 32  registered read data
//    rdata_valid    out  1   rdata updated by a read accepted last cycle
//    wbuf_valid     out  1   posted-write buffer holds undrained data
// ============================================================================
module data_sram_resp #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        wbuf_valid
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_LANES = 4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [0:c_DEPTH-1];

    logic              r_wbuf_valid;
    logic [ADDR_W-1:0] r_wbuf_idx;
    logic [31:0]       r_wbuf_data;
    logic [3:0]        r_wbuf_strb;

    logic [31:0]       r_rdata;
    logic              r_rdata_valid;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_idx;
    logic              w_is_write;
    logic              w_is_read;
    logic              w_hit;        // request targets the buffered word
    logic              w_drain;      // buffer contents go to the array this edge
    logic [31:0]       w_merged;     // array word overlaid with buffered bytes
    logic [31:0]       w_wbuf_merge; // buffer data after a same-word write merge
    logic [31:0]       w_mem_word;
    logic              w_unused_addr;

    assign w_idx         = data_sram_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign w_is_write = data_sram_en && (data_sram_wen != 4'b0000);
    assign w_is_read  = data_sram_en && (data_sram_wen == 4'b0000);
    assign w_hit      = r_wbuf_valid && (r_wbuf_idx == w_idx);

    // A write to the buffered word merges in place instead of draining, so the
    // array never sees a partially-updated intermediate value.
    assign w_drain    = r_wbuf_valid && !(w_is_write && (r_wbuf_idx == w_idx));

    assign w_mem_word = r_mem[w_idx];

    // Per-lane forwarding from the write buffer for reads.
    always_comb begin
        w_merged = w_mem_word;
        for (int i = 0; i < c_LANES; i++) begin
            if (w_hit && r_wbuf_strb[i]) begin
                w_merged[8*i +: 8] = r_wbuf_data[8*i +: 8];
            end
        end
    end

    // New strobed lanes overwrite the buffered data; others keep old bytes.
    always_comb begin
        w_wbuf_merge = r_wbuf_data;
        for (int i = 0; i < c_LANES; i++) begin
            if (data_sram_wen[i]) begin
                w_wbuf_merge[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write port: drains strobed bytes only. The array has no reset,
    // so its contents survive a reset. r_wbuf_valid is forced low by reset,
    // which blocks any drain while reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_drain) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (r_wbuf_strb[i]) begin
                    r_mem[r_wbuf_idx][8*i +: 8] <= r_wbuf_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Posted-write buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbuf_valid <= 1'b0;
            r_wbuf_idx   <= '0;
            r_wbuf_data  <= 32'h0;
            r_wbuf_strb  <= 4'h0;
        end else if (w_is_write) begin
            r_wbuf_valid <= 1'b1;
            r_wbuf_idx   <= w_idx;
            if (w_hit) begin
                r_wbuf_data <= w_wbuf_merge;
                r_wbuf_strb <= r_wbuf_strb | data_sram_wen;
            end else begin
                // Old entry (if any) drains on this same edge.
                r_wbuf_data <= data_sram_wdata;
                r_wbuf_strb <= data_sram_wen;
            end
        end else if (r_wbuf_valid) begin
            // Read or idle: the entry drains this edge.
            r_wbuf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata       <= 32'h0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_is_read;
            if (w_is_read) begin
                r_rdata <= w_merged;
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign rdata_valid     = r_rdata_valid;
    assign wbuf_valid      = r_wbuf_valid;

endmodule
`default_nettype wire

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning word-index width (memory depth 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port data_sram_en  input  1  access request this cycle.
REQ-005 The block SHALL have port data_sram_wen  input  4  byte-write strobes; bit i enables byte lane i (bits 8i+7:8i); all-zero means read.
REQ-006 The block SHALL have port data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored.
REQ-007 The block SHALL have port data_sram_wdata  input  32  store data, lane-aligned.
REQ-008 The block SHALL have port data_sram_rdata  output  32  registered read data.
REQ-009 The block SHALL have port rdata_valid  output  1  data_sram_rdata updated by a read accepted in the previous cycle.
REQ-010 The block SHALL have port wbuf_valid  output  1  posted-write buffer holds undrained data.

Function
REQ-011 Accept every request with en=1 in the cycle it is presented; no backpressure, no stall output.
REQ-012 en=0 is idle regardless of wen/addr/wdata.
REQ-013 Read (en=1, wen=0) in cycle N: rdata = merged word at the rising edge ending cycle N; rdata_valid=1 in cycle N+1 only (1-cycle latency).
REQ-014 Merged word: per byte lane, buffer byte if wbuf_valid and buffer word index matches and buffer strobe set for that lane, otherwise array byte.
REQ-015 rdata SHALL hold its last value when no read is accepted; rdata_valid=0 then.
REQ-016 Write (en=1, wen!=0): posted into one-entry write buffer (word index, 32-bit data, 4-bit strobes); array not written that cycle by this request.
REQ-017 Drain: at each edge where wbuf_valid=1 and the cycle is not a write to the buffered word index, write buffered strobed bytes into the array; unstrobed bytes unchanged.
REQ-018 Write to a different word while wbuf_valid=1: old entry drains (REQ-017) and new entry loads on the same edge; wbuf_valid stays 1.
REQ-019 Write to the buffered word: merge in buffer; new strobed lanes overwrite data, strobes OR-ed; no drain that edge.
REQ-020 Read or idle with wbuf_valid=1: drain on that edge, wbuf_valid=0 next cycle; a read in the same cycle still returns merged data (REQ-014).
REQ-021 Back-to-back writes SHALL leave at most one undrained entry; no write is ever lost except by reset.

Reset
REQ-022 Asserting reset immediately forces wbuf_valid=0, rdata_valid=0, data_sram_rdata=32'h0, buffer index/data/strobes=0.
REQ-023 Buffered undrained write is discarded on reset; array contents are not reset and retain prior values.
REQ-024 Requests presented while reset=1 are ignored; first request accepted on the first edge with reset=0.

Verification
REQ-025 Write addr=0x10 wen=4'hF wdata=0xDEADBEEF, next cycle read 0x10 -> cycle after read: rdata=0xDEADBEEF, rdata_valid=1; wbuf_valid=0 after the read cycle.
REQ-026 Write 0x20 wen=4'hF 0x11223344, then write 0x20 wen=4'b0010 0x0000AA00, then read 0x20 -> rdata=0x1122AA44.
REQ-027 Writes 0x30=0xA, 0x34=0xB, 0x38=0xC on consecutive cycles, then reads 0x30, 0x34, 0x38 -> rdata 0xA, 0xB, 0xC on successive cycles with rdata_valid=1 each.
REQ-028 Write 0x40 wen=4'b0001 0x000000FF over array word 0x12345678 (written and drained earlier), then idle, then read 0x40 -> rdata=0x123456FF.
REQ-029 Write 0x50=0x55AA55AA, assert reset before any drain, release, read 0x50 -> rdata=previous array value (not 0x55AA55AA); during reset rdata=0, rdata_valid=0, wbuf_valid=0.
REQ-030 en=0 with wen=4'hF addr=0x60 wdata=0xFFFFFFFF, then read 0x60 -> rdata equals prior array contents; wbuf_valid remains 0.
